// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder driving one 4-bit slice per clock, LSB nibble first.
// Define SUB_EN to add the sub port (a - b in two's complement).
module nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIB - 1);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [IW-1:0]    r_idx;
   logic             r_carry;
   logic [WIDTH-1:0] w_b_in;
   logic             w_cin_in;
   logic [4:0]       w_nib;
`ifdef SUB_EN
   assign w_b_in   = sub ? ~b : b;
   assign w_cin_in = cin ^ sub;
`else
   assign w_b_in   = b;
   assign w_cin_in = cin;
`endif
   assign in_ready = (r_state == IDLE);
   // carry between nibbles travels only through r_carry
   assign w_nib = {1'b0, r_a[{r_idx, 2'b00} +: 4]} + {1'b0, r_b[{r_idx, 2'b00} +: 4]} + {4'd0, r_carry};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_carry   <= 1'b0;
         r_a       <= '0;
         r_b       <= '0;
         sum       <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               r_a     <= a;
               r_b     <= w_b_in;
               r_carry <= w_cin_in;
               r_idx   <= '0;
               r_state <= CALC;
            end
            CALC: begin
               sum[{r_idx, 2'b00} +: 4] <= w_nib[3:0];
               r_carry <= w_nib[4];
               r_idx   <= r_idx + 1'b1;
               if (r_idx == LAST) begin
                  cout      <= w_nib[4];
                  out_valid <= 1'b1;
                  r_state   <= DONE;
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed vector table plus handshake, ripple and reset sequences.
module tb_nibble_serial_adder;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
`ifdef SUB_EN
   logic        sub;
`endif
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] va;
      logic [15:0] vb;
      logic        vc;
      logic        vs;
      logic [15:0] es;
      logic        ec;
      string       nm;
   } vec_t;
   vec_t vecs[$];

   nibble_serial_adder #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin),
`ifdef SUB_EN
      .sub(sub),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic wait_ready(input string nm);
      int n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_rdy"}, {31'd0, in_ready}, 32'd1);
   endtask

   task automatic drive(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic ts);
      a = ta;
      b = tb_;
`ifdef SUB_EN
      cin = tc;
      sub = ts;
`else
      cin = tc ^ ts;
`endif
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom);
   endtask

   task automatic wait_done(input string nm, input int exp_lat);
      int n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_lat"}, n, exp_lat);
   endtask

   task automatic run_op(input vec_t v);
      wait_ready(v.nm);
      drive(v.va, v.vb, v.vc, v.vs);
      wait_done(v.nm, 4);
      chk({v.nm, "_sum"}, {16'd0, sum}, {16'd0, v.es});
      chk({v.nm, "_cout"}, {31'd0, cout}, {31'd0, v.ec});
      @(posedge clk); #1;
   endtask

   task automatic ripple(input logic [15:0] ta, input logic [15:0] tb_, input logic [3:0] ecar,
                         input logic [15:0] es, input string nm);
      wait_ready(nm);
      drive(ta, tb_, 1'b0, 1'b0);
      chk({nm, "_c_init"}, {31'd0, dut.r_carry}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk($sformatf("%s_c%0d", nm, k), {31'd0, dut.r_carry}, {31'd0, ecar[k]});
      end
      chk({nm, "_ov"}, {31'd0, out_valid}, 32'd1);
      chk({nm, "_sum"}, {16'd0, sum}, {16'd0, es});
      @(posedge clk); #1;
   endtask

   initial begin
      logic [15:0] held;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
`ifdef SUB_EN
      sub = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_sum", {16'd0, sum}, 32'd0);
      chk("rst_cout", {31'd0, cout}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      vecs.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, "zero"});
      vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, "ripple"});
      vecs.push_back('{16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, "alt_cin"});
      vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, "mix"});
      vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, "top_carry"});
      vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, "max"});
      vecs.push_back('{16'h0009, 16'h0008, 1'b1, 1'b0, 16'h0012, 1'b0, "nib_carry"});
`ifdef SUB_EN
      vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, "sub_borrow"});
      vecs.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, "sub_ok"});
`endif
      foreach (vecs[i]) run_op(vecs[i]);

      ripple(16'hFFFF, 16'h0001, 4'b1111, 16'h0000, "rip_full");
      ripple(16'h00FF, 16'h0001, 4'b0011, 16'h0100, "rip_part");

      // backpressure: result must hold and a second request must wait
      out_ready = 1'b0;
      wait_ready("bp");
      drive(16'h1111, 16'h2222, 1'b0, 1'b0);
      wait_done("bp", 4);
      held = sum;
      chk("bp_sum", {16'd0, sum}, 32'h3333);
      for (int k = 0; k < 6; k++) begin
         if (k == 1) begin
            a = 16'h0101; b = 16'h0202; cin = 1'b0; in_valid = 1'b1;
         end
         @(posedge clk); #1;
         chk($sformatf("bp_hold_ov%0d", k), {31'd0, out_valid}, 32'd1);
         chk($sformatf("bp_hold_rdy%0d", k), {31'd0, in_ready}, 32'd0);
         chk($sformatf("bp_hold_sum%0d", k), {16'd0, sum}, {16'd0, held});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_rel_rdy", {31'd0, in_ready}, 32'd1);
      chk("bp_rel_ov", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      chk("bp_taken", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0;
      wait_done("bp2", 4);
      chk("bp2_sum", {16'd0, sum}, 32'h0303);
      chk("bp2_cout", {31'd0, cout}, 32'd0);
      @(posedge clk); #1;

      // asynchronous reset part-way through an operation
      wait_ready("mid");
      drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_ov", {31'd0, out_valid}, 32'd0);
      chk("mid_sum", {16'd0, sum}, 32'd0);
      chk("mid_cout", {31'd0, cout}, 32'd0);
      chk("mid_rdy", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_op('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, "after_rst"});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
